// File: rtl/pc_stat_ctrl_pkg.sv
// Shared definitions for the fetch, execute and control stages: machine status
// codes, controller state encoding, instruction codes and the fault-priority
// helper.
package pc_stat_ctrl_pkg;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  // Fixed fault priority: fetch address error beats an invalid instruction,
  // which beats a data address error, which beats a normal halt.
  function automatic stat_e fault_stat(input logic imem_error,
                                       input logic instr_valid,
                                       input logic dmem_error,
                                       input logic halt);
    if (imem_error)        return STAT_ADR;
    else if (!instr_valid) return STAT_INS;
    else if (dmem_error)   return STAT_ADR;
    else if (halt)         return STAT_HLT;
    else                   return STAT_AOK;
  endfunction

endpackage

// File: rtl/pc_stat_ctrl_if.sv
// Control/status bundle between the PC/status controller and the rest of the
// pipeline. The slave side is the controller; the master side drives it.
interface pc_stat_ctrl_if #(
  parameter int unsigned N  = 64,
  parameter int unsigned CW = 32
);
  logic          start;
  logic          step_mode;
  logic          step;
  logic [N-1:0]  PC_new;
  logic          halt;
  logic          instr_valid;
  logic          imem_error;
  logic          dmem_error;
  logic [N-1:0]  PC;
  logic [2:0]    stat;
  logic          commit_en;
  logic          running;
  logic [CW-1:0] cycle_count;
  logic [CW-1:0] instr_count;

  modport master (
    output start, step_mode, step, PC_new, halt, instr_valid, imem_error, dmem_error,
    input  PC, stat, commit_en, running, cycle_count, instr_count
  );

  modport slave (
    input  start, step_mode, step, PC_new, halt, instr_valid, imem_error, dmem_error,
    output PC, stat, commit_en, running, cycle_count, instr_count
  );
endinterface

// File: rtl/perf_counter.sv
// Free-running event counter: counts enabled cycles, wraps modulo 2^CW,
// cleared asynchronously by rst_n.
module perf_counter #(
  parameter int unsigned CW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  output logic [CW-1:0] count_o
);

  logic [CW-1:0] count_q;

  // Count enabled edges; natural overflow provides the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (en_i) begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of block ordering.
      count_q <= count_q + CW'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pc_stat_ctrl.sv
// PC register, machine status and run/step/stop control. Decides each cycle
// whether the current instruction commits, stalls (single-step) or faults.
module pc_stat_ctrl
  import pc_stat_ctrl_pkg::*;
#(
  parameter int unsigned   N        = 64,
  parameter logic [N-1:0]  RESET_PC = N'(64'd1),
  parameter int unsigned   CW       = 32
) (
  input logic           clk,
  input logic           rst_n,
  pc_stat_ctrl_if.slave bus
);

  state_e       state_q;
  logic [N-1:0] pc_q;
  stat_e        stat_q;
  logic         running_q;

  stat_e        fault_code_d;
  logic         fault_d;
  logic         commit_en_d;
  logic         cycle_en_d;

  // Fault classification and commit gate for the instruction at the current PC.
  always_comb begin
    fault_code_d = fault_stat(bus.imem_error, bus.instr_valid, bus.dmem_error, bus.halt);
    fault_d      = (state_q == ST_RUN) && (fault_code_d != STAT_AOK);
    commit_en_d  = (state_q == ST_RUN) && !fault_d && (!bus.step_mode || bus.step);
    cycle_en_d   = (state_q == ST_RUN);
  end

  // Controller FSM with PC, status and running flag as registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      stat_q    <= STAT_AOK;
      running_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (fault_d) begin
            // PC keeps the faulting instruction's address for post-mortem.
            state_q   <= ST_STOP;
            stat_q    <= fault_code_d;
            running_q <= 1'b0;
          end else if (commit_en_d) begin
            pc_q <= bus.PC_new;
          end
        end
        ST_STOP: begin
          // Sticky until reset.
        end
        default: begin
          state_q   <= ST_IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  perf_counter #(.CW(CW)) u_cycle_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (cycle_en_d),
    .count_o (bus.cycle_count)
  );

  perf_counter #(.CW(CW)) u_instr_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (commit_en_d),
    .count_o (bus.instr_count)
  );

  assign bus.PC        = pc_q;
  assign bus.stat      = stat_q;
  assign bus.commit_en = commit_en_d;
  assign bus.running   = running_q;

endmodule

// File: tb/tb_pc_stat_ctrl.sv
// Directed bench for pc_stat_ctrl: free-run, single-step, fault priority,
// sticky stop, counter wrap (CW=4 instance) and asynchronous mid-cycle reset.
module tb_pc_stat_ctrl;
  import pc_stat_ctrl_pkg::*;

  logic clk;
  logic rst_n;

  int tests_run;
  int tests_failed;
  logic [63:0] exp_pc;

  pc_stat_ctrl_if #(.N(64), .CW(32)) if64 ();
  pc_stat_ctrl_if #(.N(64), .CW(4))  if4  ();

  pc_stat_ctrl #(.N(64), .RESET_PC(64'd1), .CW(32)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if64)
  );

  pc_stat_ctrl #(.N(64), .RESET_PC(64'd1), .CW(4)) u_dut_cw4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if64.start = 1'b0; if64.step_mode = 1'b0; if64.step = 1'b0; if64.PC_new = '0;
    if64.halt = 1'b0; if64.instr_valid = 1'b1; if64.imem_error = 1'b0; if64.dmem_error = 1'b0;
    if4.start = 1'b0; if4.step_mode = 1'b0; if4.step = 1'b0; if4.PC_new = '0;
    if4.halt = 1'b0; if4.instr_valid = 1'b1; if4.imem_error = 1'b0; if4.dmem_error = 1'b0;
  endtask

  // Reset both instances; release away from the rising edge.
  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = 64'd1;
  endtask

  task automatic start_run();
    if64.start = 1'b1;
    tick();
    if64.start = 1'b0;
  endtask

  // One committed free-run instruction on the CW=32 instance.
  task automatic commit_one(input logic [63:0] next_pc);
    if64.PC_new = next_pc;
    tick();
    exp_pc = next_pc;
  endtask

  // Commit once to reach PC=0x20, then present a fault pattern with
  // step_mode=1/step=0 so the fault must win regardless of stepping.
  task automatic run_fault(input string tag, input logic imem, input logic iv,
                           input logic dmem, input logic hlt, input logic [2:0] exp_stat);
    do_reset();
    start_run();
    commit_one(64'h20);
    if64.imem_error = imem; if64.instr_valid = iv; if64.dmem_error = dmem; if64.halt = hlt;
    if64.step_mode = 1'b1; if64.step = 1'b0; if64.PC_new = 64'h40;
    #1;
    check({tag, "_commit_en"}, 64'(if64.commit_en), 64'd0);
    tick();
    check({tag, "_stat"},    64'(if64.stat), 64'(exp_stat));
    check({tag, "_running"}, 64'(if64.running), 64'd0);
    check({tag, "_pc"},      if64.PC, 64'h20);
    check({tag, "_icount"},  64'(if64.instr_count), 64'd1);
    check({tag, "_ccount"},  64'(if64.cycle_count), 64'd2);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    exp_pc       = 64'd1;
    rst_n        = 1'b0;
    idle_inputs();

    // Reset values, then free-run with PC_new = PC+2.
    do_reset();
    check("rst_pc",      if64.PC, 64'd1);
    check("rst_stat",    64'(if64.stat), 64'd1);
    check("rst_ccount",  64'(if64.cycle_count), 64'd0);
    check("rst_icount",  64'(if64.instr_count), 64'd0);
    check("rst_running", 64'(if64.running), 64'd0);
    check("rst_commit",  64'(if64.commit_en), 64'd0);
    if64.start = 1'b1;
    #1;
    check("idle_commit", 64'(if64.commit_en), 64'd0);
    tick();
    if64.start = 1'b0;
    check("run_running", 64'(if64.running), 64'd1);
    check("run_pc0",     if64.PC, 64'd1);
    for (int i = 0; i < 5; i++) begin
      if64.PC_new = exp_pc + 64'd2;
      #1;
      check("free_commit", 64'(if64.commit_en), 64'd1);
      tick();
      exp_pc = exp_pc + 64'd2;
      check("free_pc", if64.PC, exp_pc);
    end
    check("free_pc_final", if64.PC, 64'd11);
    check("free_icount",   64'(if64.instr_count), 64'd5);
    check("free_ccount",   64'(if64.cycle_count), 64'd5);
    check("free_stat",     64'(if64.stat), 64'd1);

    // Single-step: step on RUN cycles 2 and 5 of 6.
    do_reset();
    if64.step_mode = 1'b1;
    start_run();
    for (int c = 1; c <= 6; c++) begin
      if64.step   = (c == 2) || (c == 5);
      if64.PC_new = exp_pc + 64'd4;
      #1;
      check("step_commit", 64'(if64.commit_en), 64'(if64.step));
      tick();
      if ((c == 2) || (c == 5)) exp_pc = exp_pc + 64'd4;
      check("step_pc", if64.PC, exp_pc);
    end
    if64.step = 1'b0;
    check("step_pc_final", if64.PC, 64'd9);
    check("step_icount",   64'(if64.instr_count), 64'd2);
    check("step_ccount",   64'(if64.cycle_count), 64'd6);

    // Fault priority.
    run_fault("imem_inv",  1'b1, 1'b0, 1'b0, 1'b0, 3'd3);
    run_fault("inv_dmem",  1'b0, 1'b0, 1'b1, 1'b1, 3'd4);
    run_fault("dmem_halt", 1'b0, 1'b1, 1'b1, 1'b1, 3'd3);
    run_fault("halt_only", 1'b0, 1'b1, 1'b0, 1'b1, 3'd2);

    // Halt after 3 commits, then STOP must ignore everything.
    do_reset();
    start_run();
    for (int i = 0; i < 3; i++) commit_one(exp_pc + 64'd1);
    if64.halt = 1'b1;
    tick();
    check("halt_stat",   64'(if64.stat), 64'd2);
    check("halt_ccount", 64'(if64.cycle_count), 64'd4);
    check("halt_icount", 64'(if64.instr_count), 64'd3);
    check("halt_pc",     if64.PC, 64'd4);
    for (int k = 0; k < 4; k++) begin
      if64.start       = 1'b1;
      if64.step        = k[0];
      if64.step_mode   = k[0];
      if64.halt        = k[1];
      if64.imem_error  = k[0];
      if64.dmem_error  = ~k[0];
      if64.instr_valid = k[1];
      if64.PC_new      = {$urandom, $urandom};
      #1;
      check("stop_commit", 64'(if64.commit_en), 64'd0);
      tick();
    end
    check("stop_stat",    64'(if64.stat), 64'd2);
    check("stop_ccount",  64'(if64.cycle_count), 64'd4);
    check("stop_icount",  64'(if64.instr_count), 64'd3);
    check("stop_pc",      if64.PC, 64'd4);
    check("stop_running", 64'(if64.running), 64'd0);

    // CW=4 instance: 17 commits wrap both counters to 1.
    do_reset();
    if4.start = 1'b1;
    tick();
    if4.start = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if4.PC_new = exp_pc + 64'd1;
      tick();
      exp_pc = exp_pc + 64'd1;
    end
    check("wrap_icount", 64'(if4.instr_count), 64'd1);
    check("wrap_ccount", 64'(if4.cycle_count), 64'd1);
    check("wrap_pc",     if4.PC, 64'd18);

    // Asynchronous reset between edges while a commit is pending.
    do_reset();
    start_run();
    commit_one(exp_pc + 64'd2);
    commit_one(exp_pc + 64'd2);
    check("areset_pre_pc", if64.PC, 64'd5);
    if64.PC_new = exp_pc + 64'd2;
    #1;
    check("areset_pre_commit", 64'(if64.commit_en), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_pc",      if64.PC, 64'd1);
    check("areset_stat",    64'(if64.stat), 64'd1);
    check("areset_ccount",  64'(if64.cycle_count), 64'd0);
    check("areset_icount",  64'(if64.instr_count), 64'd0);
    check("areset_running", 64'(if64.running), 64'd0);
    check("areset_commit",  64'(if64.commit_en), 64'd0);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("areset_idle_running", 64'(if64.running), 64'd0);
    check("areset_idle_pc",      if64.PC, 64'd1);
    check("areset_idle_ccount",  64'(if64.cycle_count), 64'd0);
    check("areset_idle_icount",  64'(if64.instr_count), 64'd0);
    start_run();
    check("restart_running", 64'(if64.running), 64'd1);
    check("restart_ccount",  64'(if64.cycle_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
